// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter and transaction sequencer in
// front of a Wishbone-style system bus master port.
//
//   m0 (instruction fetch) / m1 (data memory):
//     mX_req_i, mX_addr_i, mX_data_i, mX_we_i   request side, held until ack/err
//     mX_data_o, mX_ack_o, mX_err_o             one-cycle response, granted master only
//   bus side:
//     bus_addr_o, bus_data_o, bus_we_o, bus_select_o (16-bit one-hot slave select)
//     bus_data_i, bus_ack_i
//   status:
//     grant_o (one-hot owner, 0 in IDLE), busy_o (BUSY or RESP)
//
// Flow: IDLE samples requests and latches the winner, BUSY holds the bus until
// ack or TIMEOUT cycles, RESP returns one ack/err pulse and goes back to IDLE.
// Every output is a flop; reset is synchronous, active-high.

// Per-master response register: one-cycle ack/err pulse with read data.
// data_o is zero except while ack_o is high; ack takes priority over err.
module bus_arbiter_rsp (
    input  logic        clk,
    input  logic        rst,
    input  logic        ack_set_i,
    input  logic        err_set_i,
    input  logic [31:0] data_i,
    output logic        ack_o,
    output logic        err_o,
    output logic [31:0] data_o
);
    logic        ack_q;
    logic        err_q;
    logic [31:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            data_q <= '0;
        end else begin
            ack_q  <= ack_set_i;
            err_q  <= err_set_i & ~ack_set_i;
            data_q <= ack_set_i ? data_i : '0;
        end
    end

    assign ack_o  = ack_q;
    assign err_o  = err_q;
    assign data_o = data_q;
endmodule

module bus_arbiter #(
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned NUM_SLAVES = 8
) (
    input  logic        clk,
    input  logic        rst,
    // master 0: instruction fetch
    input  logic        m0_req_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    input  logic        m0_we_i,
    output logic [31:0] m0_data_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    // master 1: data memory
    input  logic        m1_req_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    input  logic        m1_we_i,
    output logic [31:0] m1_data_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    // system bus
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_data_o,
    output logic        bus_we_o,
    output logic [15:0] bus_select_o,
    input  logic [31:0] bus_data_i,
    input  logic        bus_ack_i,
    // status
    output logic [1:0]  grant_o,
    output logic        busy_o
);
    localparam int         NUM_M    = 2;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [4:0] SLV_LIM  = 5'(NUM_SLAVES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Master request side gathered into packed per-master arrays.
    logic [NUM_M-1:0]       req;
    logic [NUM_M-1:0][31:0] addr;
    logic [NUM_M-1:0][31:0] wdata;
    logic [NUM_M-1:0]       we;

    assign req   = {m1_req_i, m0_req_i};
    assign addr  = {m1_addr_i, m0_addr_i};
    assign wdata = {m1_data_i, m0_data_i};
    assign we    = {m1_we_i, m0_we_i};

    state_t           state_q, state_d;
    logic             last_q, last_d;       // index of the master granted last
    logic [NUM_M-1:0] grant_q, grant_d;
    logic             busy_q, busy_d;
    logic [31:0]      bus_addr_q, bus_addr_d;
    logic [31:0]      bus_data_q, bus_data_d;
    logic             bus_we_q, bus_we_d;
    logic [15:0]      bus_sel_q, bus_sel_d;
    logic [7:0]       cnt_q, cnt_d;

    logic             win;
    logic [3:0]       idx;
    logic [NUM_M-1:0] rsp_ack;
    logic [NUM_M-1:0] rsp_err;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        grant_d    = grant_q;
        busy_d     = busy_q;
        bus_addr_d = bus_addr_q;
        bus_data_d = bus_data_q;
        bus_we_d   = bus_we_q;
        bus_sel_d  = bus_sel_q;
        cnt_d      = cnt_q;
        win        = 1'b0;
        idx        = 4'd0;
        rsp_ack    = '0;
        rsp_err    = '0;

        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    // On a tie the master not granted last wins; otherwise the
                    // single requester (req==01 -> 0, req==10 -> 1).
                    win     = (req == 2'b11) ? ~last_q : req[1];
                    idx     = addr[win][31:28];
                    last_d  = win;
                    grant_d = 2'b01 << win;
                    busy_d  = 1'b1;
                    if ({1'b0, idx} < SLV_LIM) begin
                        bus_sel_d  = 16'h0001 << idx;
                        bus_addr_d = addr[win];
                        bus_data_d = wdata[win];
                        bus_we_d   = we[win];
                        cnt_d      = 8'd0;
                        state_d    = S_BUSY;
                    end else begin
                        // Unmapped: never touches the bus, straight to error.
                        rsp_err[win] = 1'b1;
                        state_d      = S_RESP;
                    end
                end
            end

            S_BUSY: begin
                cnt_d = cnt_q + 8'd1;
                // Ack is checked first so a last-cycle ack beats the timeout.
                if (bus_ack_i || (cnt_q == CNT_LAST)) begin
                    if (bus_ack_i) begin
                        rsp_ack = grant_q;
                    end else begin
                        rsp_err = grant_q;
                    end
                    bus_sel_d  = '0;
                    bus_we_d   = 1'b0;
                    bus_addr_d = '0;
                    bus_data_d = '0;
                    state_d    = S_RESP;
                end
            end

            S_RESP: begin
                // Requests are not sampled here; the master drops req on the
                // edge that shows it ack/err, so IDLE never re-grants it.
                grant_d = '0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d    = S_IDLE;
                grant_d    = '0;
                busy_d     = 1'b0;
                bus_sel_d  = '0;
                bus_we_d   = 1'b0;
                bus_addr_d = '0;
                bus_data_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            last_q     <= 1'b1;             // m0 wins the first tie
            grant_q    <= '0;
            busy_q     <= 1'b0;
            bus_addr_q <= '0;
            bus_data_q <= '0;
            bus_we_q   <= 1'b0;
            bus_sel_q  <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            bus_addr_q <= bus_addr_d;
            bus_data_q <= bus_data_d;
            bus_we_q   <= bus_we_d;
            bus_sel_q  <= bus_sel_d;
            cnt_q      <= cnt_d;
        end
    end

    // Response registers, one per master.
    logic [NUM_M-1:0]       m_ack;
    logic [NUM_M-1:0]       m_err;
    logic [NUM_M-1:0][31:0] m_rdata;

    for (genvar g = 0; g < NUM_M; g++) begin : g_rsp
        bus_arbiter_rsp u_rsp (
            .clk       (clk),
            .rst       (rst),
            .ack_set_i (rsp_ack[g]),
            .err_set_i (rsp_err[g]),
            .data_i    (bus_data_i),
            .ack_o     (m_ack[g]),
            .err_o     (m_err[g]),
            .data_o    (m_rdata[g])
        );
    end

    assign m0_ack_o     = m_ack[0];
    assign m0_err_o     = m_err[0];
    assign m0_data_o    = m_rdata[0];
    assign m1_ack_o     = m_ack[1];
    assign m1_err_o     = m_err[1];
    assign m1_data_o    = m_rdata[1];

    assign bus_addr_o   = bus_addr_q;
    assign bus_data_o   = bus_data_q;
    assign bus_we_o     = bus_we_q;
    assign bus_select_o = bus_sel_q;
    assign grant_o      = grant_q;
    assign busy_o       = busy_q;
endmodule
